// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchroniser, debouncer and hold-to-repeat
// generator. Each key runs in its own key_conditioner_chan instance, so
// channels share nothing but the clock and reset.

module key_conditioner_chan #(
  parameter int DEB_CYCLES    = 240_000,
  parameter int REPEAT_DELAY  = 6_000_000,
  parameter int REPEAT_PERIOD = 1_200_000,
  parameter bit REP_EN        = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,   // polarity-normalised raw level, 1 = pressed
  output logic level,
  output logic press,
  output logic rel,
  output logic rep
);

  localparam int DW   = $clog2(DEB_CYCLES);
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEATING = 2'd2
  } st_t;

  logic          sync_q, s;
  logic [DW-1:0] dcnt;
  logic          diff, acc, acc_press, acc_rel;
  st_t           st, st_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic          rep_evt;

  // Two-flop synchroniser; resets to "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_q <= key_in;
      s      <= sync_q;
    end
  end

  // A change is accepted on the cycle the counter has seen DEB_CYCLES
  // consecutive differing samples; any bounce back clears the count.
  assign diff      = s ^ level;
  assign acc       = diff & (dcnt == DEB_LAST);
  assign acc_press = acc & ~level;
  assign acc_rel   = acc & level;

  // Debounce counter and accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt  <= '0;
      level <= 1'b0;
    end else if (!diff) begin
      dcnt  <= '0;
    end else if (acc) begin
      dcnt  <= '0;
      level <= ~level;
    end else begin
      dcnt  <= dcnt + 1'b1;
    end
  end

  // Hold/repeat state and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      hcnt <= '0;
    end else begin
      st   <= st_nxt;
      hcnt <= hcnt_nxt;
    end
  end

  // Next state: the counter reloads before reaching its bound so it
  // never wraps; an accepted release overrides any repeat that would
  // have fired on the same cycle.
  always_comb begin
    st_nxt   = st;
    hcnt_nxt = hcnt;
    rep_evt  = 1'b0;
    case (st)
      IDLE: begin
        if (acc_press && REP_EN) begin
          st_nxt   = HOLD_WAIT;
          hcnt_nxt = '0;
        end
      end
      HOLD_WAIT: begin
        if (hcnt == DLY_LAST) begin
          st_nxt   = REPEATING;
          hcnt_nxt = '0;
          rep_evt  = 1'b1;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      REPEATING: begin
        if (hcnt == PER_LAST) begin
          hcnt_nxt = '0;
          rep_evt  = 1'b1;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      default: begin
        st_nxt   = IDLE;
        hcnt_nxt = '0;
      end
    endcase
    if (acc_rel) begin
      st_nxt   = IDLE;
      hcnt_nxt = '0;
      rep_evt  = 1'b0;
    end
  end

  // Registered one-cycle event pulses, visible the cycle after the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press <= 1'b0;
      rel   <= 1'b0;
      rep   <= 1'b0;
    end else begin
      press <= acc_press;
      rel   <= acc_rel;
      rep   <= rep_evt;
    end
  end

endmodule

module key_conditioner #(
  parameter int                  NUM_KEYS      = 4,
  parameter int                  ACTIVE_LOW    = 1,
  parameter int                  DEB_CYCLES    = 240_000,
  parameter int                  REPEAT_DELAY  = 6_000_000,
  parameter int                  REPEAT_PERIOD = 1_200_000,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK   = {NUM_KEYS{1'b1}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic [NUM_KEYS-1:0] key_evt
);

  localparam logic POL = (ACTIVE_LOW != 0);

  logic [NUM_KEYS-1:0] key_norm;

  // Normalise so that 1 always means pressed.
  assign key_norm = key_raw ^ {NUM_KEYS{POL}};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_conditioner_chan #(
      .DEB_CYCLES    (DEB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .REP_EN        (REPEAT_MASK[g])
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_in (key_norm[g]),
      .level  (key_level[g]),
      .press  (key_press[g]),
      .rel    (key_release[g]),
      .rep    (key_repeat[g])
    );
  end

  // Both sources are registered, so evt keeps their cycle alignment.
  assign key_evt = key_press | key_repeat;

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input conditioning stage that sits directly upstream of the traffic-light controller's key handling. It takes raw, bouncing, asynchronous pushbutton and slide-switch levels from the board and produces synchronised, debounced levels, single-cycle press/release pulses, and hold-to-repeat pulses. The controller's plus/sub adjustment consumes `key_evt`. The mode selection consumes `key_level`.

## Interface
- `NUM_KEYS`, default 4: number of independent key channels.
- `ACTIVE_LOW`, default 1: 1 = raw input reads 0 when pressed; 0 = raw input reads 1 when pressed.
- `DEB_CYCLES`, default 240_000: stability window in clk cycles (20 ms @ 12 MHz). Must be ≥ 2.
- `REPEAT_DELAY`, default 6_000_000: cycles from press pulse to first repeat pulse (0.5 s).
- `REPEAT_PERIOD`, default 1_200_000: cycles between subsequent repeat pulses (0.1 s).
- `REPEAT_MASK`, default {NUM_KEYS{1'b1}}: bit i = 1 enables auto-repeat on channel i.

Ports:
- `clk`: input, 1 bit. System clock (12 MHz).
- `rst_n`: input, 1 bit. Reset, asynchronous, active-low.
- `key_raw`: input, NUM_KEYS bits. Raw board levels, asynchronous to clk.
- `key_level`: output, NUM_KEYS bits. Debounced state, active-high (1 = pressed).
- `key_press`: output, NUM_KEYS bits. One-cycle pulse when a press is accepted.
- `key_release`: output, NUM_KEYS bits. One-cycle pulse when a release is accepted.
- `key_repeat`: output, NUM_KEYS bits. One-cycle pulse per auto-repeat while held.
- `key_evt`: output, NUM_KEYS bits. Equals key_press | key_repeat.

## Operation
- Each channel is fully independent; there is no shared arbitration.
- Polarity normalisation: p = key_raw ^ {NUM_KEYS{ACTIVE_LOW}}, so 1 means pressed.
- Synchroniser: two flops per channel. Reset value is 0 (released). The synchronised output is s.
- Debounce counter: width $clog2(DEB_CYCLES).
  - When s == key_level: the counter clears to 0.
  - When s != key_level: the counter increments.
  - On the cycle the counter equals DEB_CYCLES-1 and s still differs: key_level toggles, the counter clears, and the matching press or release pulse asserts on the next cycle.
- Hold/repeat FSM per channel, states IDLE, HOLD_WAIT, REPEATING:
  - IDLE → HOLD_WAIT on an accepted press, if REPEAT_MASK[i] = 1. The hold counter loads 0.
  - HOLD_WAIT → REPEATING when the hold counter reaches REPEAT_DELAY-1. This emits key_repeat and reloads the hold counter to 0.
  - REPEATING: emits key_repeat each time the hold counter reaches REPEAT_PERIOD-1, then reloads it.
  - Any state → IDLE on an accepted release. The hold counter clears.
- Channels with REPEAT_MASK[i] = 0 stay in IDLE permanently; key_repeat[i] is constant 0.
- Hold counter width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)). It never wraps, because it reloads before reaching its bound.

## Timing
- Reset: every output is 0, all counters are 0, and every FSM is in IDLE. All flops are asynchronously cleared.
- Press latency: a clean raw edge at clock k gives key_press and key_level = 1 at clock k + 2 + DEB_CYCLES.
- Release latency is the same: key_release at k + 2 + DEB_CYCLES.
- key_press and key_release are exactly one cycle wide. A key_press pulse is never followed by another press without an intervening release.
- First key_repeat: REPEAT_DELAY cycles after the key_press pulse. Subsequent pulses follow every REPEAT_PERIOD cycles.
- Glitch rejection: any excursion of s shorter than DEB_CYCLES cycles produces no level change and no pulse. Each bounce back restarts the count from 0.
- Release versus repeat in the same cycle: release wins. key_repeat is suppressed on the cycle the release is accepted and on every cycle after it.
- key_evt is combinational OR of registered pulses, so it has the same cycle alignment as key_press and key_repeat.
- Reset mid-hold: outputs drop to 0 immediately. If the key is still held after rst_n deasserts, a fresh key_press appears 2 + DEB_CYCLES cycles later, and repeat timing restarts from that pulse.
- Simultaneous presses on several channels produce simultaneous independent pulses.

## Test plan
Use DEB_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, NUM_KEYS=4, ACTIVE_LOW=1.
- Clean press: key_raw[0] goes 1→0 at cycle 10 and is held. Required: key_press[0] one cycle at cycle 20, key_level[0]=1 from cycle 20, key_evt[0] pulses at 20.
- Bounce: key_raw[1] toggles every 3 cycles for 30 cycles, then stays low. Required: no pulse during bouncing; exactly one key_press[1], 10 cycles after the final transition.
- Auto-repeat: hold key 0 after its press pulse at cycle P. Required: key_repeat[0] at P+20, P+25, P+30; release at R gives key_release[0] at R+10 and no repeat after it. Repeat channel 2 with REPEAT_MASK[2]=0 and require key_repeat[2] to stay 0.
- Release coincident with repeat: time the release acceptance onto a scheduled repeat cycle. Required: key_release=1 and key_repeat=0 on that cycle.
- Reset mid-hold: assert rst_n low for 3 cycles while key 3 is held and repeating. Required: all outputs 0 immediately; after deassertion, key_press[3] exactly 10 cycles later.
- Multi-key: press keys 0 and 2 on the same cycle. Required: both key_press bits pulse on the same cycle; keys 1 and 3 show no activity.
